// File: rtl/conv_pkg.sv
// Shared widths, types and constants for the 3x3 convolution engine.
// Default widths: 8-bit pixels, 9-bit signed coefficients.
package conv_pkg;

    localparam int PIXEL_W = 8;
    localparam int COEF_W  = 9;
    localparam int PROD_W  = 18;
    localparam int ROW_W   = 20;
    localparam int SUM_W   = 22;

    typedef logic [2:0][2:0][COEF_W-1:0]  kernel_t;
    typedef logic [2:0][2:0][PIXEL_W-1:0] window_t;

    // Centre tap [1][1] sits at flat element 4.
    localparam kernel_t KERNEL_IDENTITY =
        kernel_t'(1) << (4 * COEF_W);

endpackage

// File: rtl/conv_sat.sv
// Arithmetic right shift and clamp of a signed sum
// to an unsigned pixel.
module conv_sat
    import conv_pkg::*;
#(
    parameter int IN_W  = SUM_W,
    parameter int OUT_W = PIXEL_W,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  sum_i,
    output logic        [OUT_W-1:0] pix_o
);

    logic signed [IN_W-1:0] sh;

    assign sh = sum_i >>> SHIFT;

    always_comb begin
        pix_o = sh[OUT_W-1:0];
        if (sh[IN_W-1]) begin
            pix_o = '0;
        end else if (|sh[IN_W-2:OUT_W]) begin
            pix_o = '1;
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 convolution: multiply, row-sum, total/saturate stages
// advancing together under one global enable.
module conv3x3_engine #(
    parameter int PIXEL_W = 8,
    parameter int COEF_W  = 9,
    parameter int SHIFT   = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [2:0][2:0][COEF_W-1:0]   filter_i,
    input  logic                          filter_v_i,
    input  logic [2:0][2:0][PIXEL_W-1:0]  window_i,
    input  logic                          sof_i,
    input  logic                          v_i,
    output logic                          ready_o,
    output logic [PIXEL_W-1:0]            data_o,
    output logic                          v_o,
    input  logic                          ready_i
);

    localparam int PRW  = COEF_W + PIXEL_W + 1;
    localparam int RW   = PRW + 2;
    localparam int SW   = PRW + 4;
    localparam int KW   = 9 * COEF_W;

    localparam logic [2:0][2:0][COEF_W-1:0] K_ID =
        KW'(1) << (4 * COEF_W);

    logic                          en;
    logic                          acc;
    logic                          kloaded_r;
    logic                          v1_r;
    logic                          v2_r;
    logic [2:0][2:0][COEF_W-1:0]   kernel_r;
    logic [2:0][2:0][COEF_W-1:0]   kern;
    logic signed [PRW-1:0]         prod_d [3][3];
    logic signed [PRW-1:0]         prod_r [3][3];
    logic signed [RW-1:0]          row_d  [3];
    logic signed [RW-1:0]          row_r  [3];
    logic signed [SW-1:0]          total;
    logic [PIXEL_W-1:0]            pix;

    assign en      = !v_o || ready_i;
    assign ready_o = en && (sof_i ? filter_v_i
                                  : (filter_v_i || kloaded_r));
    assign acc     = v_i && ready_o;
    // Before the first frame start the live kernel is used unlatched.
    assign kern    = (sof_i || !kloaded_r) ? filter_i : kernel_r;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                prod_d[r][c] =
                    PRW'($signed(kern[r][c])) *
                    PRW'($signed({1'b0, window_i[r][c]}));
            end
            row_d[r] = RW'(prod_r[r][0]) +
                       RW'(prod_r[r][1]) +
                       RW'(prod_r[r][2]);
        end
    end

    assign total = SW'(row_r[0]) + SW'(row_r[1]) + SW'(row_r[2]);

    conv_sat #(
        .IN_W  (SW),
        .OUT_W (PIXEL_W),
        .SHIFT (SHIFT)
    ) u_sat (
        .sum_i (total),
        .pix_o (pix)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            kernel_r  <= K_ID;
            kloaded_r <= 1'b0;
        end else if (acc && sof_i) begin
            kernel_r  <= filter_i;
            kloaded_r <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
            v_o    <= 1'b0;
            data_o <= '0;
            prod_r <= '{default: '0};
            row_r  <= '{default: '0};
        end else if (en) begin
            v1_r   <= acc;
            v2_r   <= v1_r;
            v_o    <= v2_r;
            prod_r <= prod_d;
            row_r  <= row_d;
            if (v2_r) begin
                data_o <= pix;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Bench for conv3x3_engine: vector table, random backpressured
// stream and mid-stream reset, all checked through a scoreboard.
module tb_conv3x3_engine;
    import conv_pkg::*;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    kernel_t       filter_i;
    logic          filter_v_i;
    window_t       window_i;
    logic          sof_i;
    logic          v_i;
    logic          ready_o;
    logic [7:0]    data_o;
    logic          v_o;
    logic          ready_i;

    always #5 clk_i = ~clk_i;

    conv3x3_engine #(
        .PIXEL_W (8),
        .COEF_W  (9),
        .SHIFT   (0)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .filter_i   (filter_i),
        .filter_v_i (filter_v_i),
        .window_i   (window_i),
        .sof_i      (sof_i),
        .v_i        (v_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .v_o        (v_o),
        .ready_i    (ready_i)
    );

    typedef int nine_t [9];
    typedef struct {
        kernel_t k;
        window_t w;
        bit      sof;
        bit      fv;
        int      exp;
    } vec_t;
    typedef struct {
        int exp;
        int t_in;
    } sb_t;

    sb_t      sbq [$];
    vec_t     tbl [11];
    int       n_chk = 0;
    int       n_err = 0;
    int       cyc = 0;
    int       n_out = 0;
    int       cur_exp = 0;
    bit       kl_m = 0;
    kernel_t  km;
    bit       bp = 0;
    int       bp_i = 0;
    bit [3:0] pat = 4'b1001;

    function automatic kernel_t mkk(nine_t p);
        kernel_t k;
        for (int i = 0; i < 9; i++)
            k[2 - i / 3][2 - i % 3] = COEF_W'(p[i]);
        return k;
    endfunction

    function automatic window_t mkw(nine_t p);
        window_t w;
        for (int i = 0; i < 9; i++)
            w[2 - i / 3][2 - i % 3] = PIXEL_W'(p[i]);
        return w;
    endfunction

    function automatic window_t cw(int ctr, int oth);
        window_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = PIXEL_W'(oth);
        w[1][1] = PIXEL_W'(ctr);
        return w;
    endfunction

    function automatic vec_t mkv(kernel_t k, window_t w,
                                 bit s, bit f, int e);
        vec_t v;
        v.k = k;
        v.w = w;
        v.sof = s;
        v.fv = f;
        v.exp = e;
        return v;
    endfunction

    function automatic int conv_ref(kernel_t k, window_t w);
        int s;
        int kv;
        s = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                kv = $signed(k[r][c]);
                s += kv * int'(w[r][c]);
            end
        end
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic check(string nm, logic [31:0] act,
                         logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d",
                     nm, act, exp);
        end
    endtask

    // One clock: sample mid-low-phase, then move to next negedge.
    task automatic cycle(output bit acc);
        sb_t e;
        bit  er;
        #4;
        er = (!v_o || ready_i) &&
             (sof_i ? filter_v_i : (filter_v_i || kl_m));
        check("ready_o", ready_o, er);
        acc = v_i && ready_o;
        if (acc) begin
            sbq.push_back('{cur_exp, cyc});
            if (sof_i) begin
                kl_m = 1;
                km = filter_i;
            end
        end
        if (v_o && ready_i) begin
            n_out++;
            if (sbq.size() == 0) begin
                check("spurious_v_o", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("data_o", data_o, e.exp);
                if (!bp) check("latency", cyc - e.t_in, 3);
            end
        end
        cyc++;
        @(negedge clk_i);
        if (bp) begin
            ready_i = pat[bp_i % 4];
            bp_i++;
        end
    endtask

    task automatic send(kernel_t k, window_t w, bit sof,
                        bit fv, int ex);
        bit acc;
        acc = 0;
        filter_i = k;
        window_i = w;
        sof_i = sof;
        filter_v_i = fv;
        v_i = 1;
        cur_exp = ex;
        for (int i = 0; i < 40 && !acc; i++) cycle(acc);
        if (!acc) check("accept_timeout", 0, 1);
        v_i = 0;
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 60 && sbq.size() > 0; i++)
            cycle(a);
        check("drain_left", sbq.size(), 0);
        repeat (6) cycle(a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        kernel_t kid, khp, kemb, kshp, kk, fr;
        window_t w;
        nine_t   p;
        bit      a;
        int      n0;
        int      ex;

        kid  = mkk('{0, 0, 0, 0, 1, 0, 0, 0, 0});
        khp  = mkk('{-1, -1, -1, -1, 8, -1, -1, -1, -1});
        kemb = mkk('{-2, -1, 0, -1, 1, 1, 0, 1, 2});
        kshp = mkk('{0, -1, 0, -1, 5, -1, 0, -1, 0});

        tbl[0]  = mkv(kid,  cw(77, 200), 1, 1, 77);
        tbl[1]  = mkv(khp,  cw(100, 100), 1, 1, 0);
        tbl[2]  = mkv(khp,  cw(255, 0), 0, 1, 255);
        tbl[3]  = mkv(khp,  cw(0, 255), 0, 1, 0);
        tbl[4]  = mkv(kemb, mkw('{10, 20, 30, 40, 50,
                                  60, 70, 80, 90}), 1, 1, 255);
        tbl[5]  = mkv(kid,  cw(50, 10), 1, 1, 50);
        tbl[6]  = mkv(kshp, cw(50, 10), 0, 1, 50);
        tbl[7]  = mkv(kshp, cw(50, 10), 0, 0, 50);
        tbl[8]  = mkv(kshp, cw(50, 10), 1, 1, 210);
        tbl[9]  = mkv(kid,  cw(0, 255), 1, 1, 0);
        tbl[10] = mkv(kemb, mkw('{1, 2, 3, 4, 5,
                                  6, 7, 8, 9}), 1, 1, 29);

        filter_i = '0;
        filter_v_i = 0;
        window_i = '0;
        sof_i = 0;
        v_i = 0;
        ready_i = 1;
        repeat (2) @(negedge clk_i);
        check("rst_v_o", v_o, 0);
        check("rst_data_o", data_o, 0);
        reset_i = 1;

        v_i = 1;
        cycle(a);
        check("unloaded_nonsof_blocked", a, 0);
        v_i = 0;

        for (int i = 0; i < 11; i++)
            send(tbl[i].k, tbl[i].w, tbl[i].sof,
                 tbl[i].fv, tbl[i].exp);
        drain();

        bp = 1;
        bp_i = 1;
        ready_i = pat[0];
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 9; j++)
                p[j] = int'($urandom_range(0, 6)) - 3;
            fr = mkk(p);
            for (int j = 0; j < 9; j++)
                p[j] = int'($urandom_range(0, 255));
            w = mkw(p);
            kk = (i == 0 || !kl_m) ? fr : km;
            ex = conv_ref(kk, w);
            send(fr, w, i == 0, 1, ex);
        end
        drain();
        check("bp_out_count", n_out - n0, 8);
        bp = 0;
        ready_i = 1;

        send(kid, cw(11, 3), 1, 1, 11);
        send(kid, cw(22, 3), 0, 1, 22);
        send(kid, cw(33, 3), 0, 1, 33);
        check("inflight_v_o", v_o, 1);
        reset_i = 0;
        #1;
        check("async_rst_v_o", v_o, 0);
        check("async_rst_data_o", data_o, 0);
        sbq.delete();
        kl_m = 0;
        repeat (2) @(negedge clk_i);
        reset_i = 1;

        filter_v_i = 0;
        sof_i = 0;
        v_i = 1;
        cycle(a);
        check("post_rst_nonsof_blocked", a, 0);
        v_i = 0;
        send(kshp, cw(50, 10), 0, 1, 210);
        send(kid, cw(44, 5), 0, 1, 44);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
- Consumer end of the kernel-select interface: takes the 3x3 signed coefficient array and its valid flag, plus a stream of 3x3 pixel windows from the line buffer.
- Computes one saturated output pixel per accepted window through a 3-stage stallable pipeline.
- Sits between the line-buffer/window generator and the VGA output formatter.
- Kernel is latched only at frame start, so a switch change mid-frame cannot tear the image.

Parameters:
- PIXEL_W, 8, unsigned pixel width for input and output.
- COEF_W, 9, signed coefficient width; two's complement, range -256..255.
- SHIFT, 0, arithmetic right shift applied to the sum before saturation; used for normalised kernels such as blur.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- filter_i  in  [2:0][2:0][COEF_W-1:0]  kernel from the selector; [row][col], row 2/col 2 is top-left.
- filter_v_i  in  1  kernel valid.
- window_i  in  [2:0][2:0][PIXEL_W-1:0]  pixel window, same indexing as filter_i.
- sof_i  in  1  window is the first of a frame.
- v_i  in  1  window valid.
- ready_o  out  1  engine accepts a window this cycle.
- data_o  out  PIXEL_W  filtered pixel.
- v_o  out  1  data_o valid.
- ready_i  in  1  downstream accepts data_o.

Behaviour:
- Reset (async assert, sync-released use):
  - All stage valids = 0; v_o = 0; data_o = 0.
  - kernel_r = identity (centre = 1, all others 0); kloaded_r = 0.
- Handshake:
  - Input transfer occurs when v_i & ready_o.
  - Output transfer occurs when v_o & ready_i.
  - data_o holds stable while v_o & ~ready_i.
- Pipeline enable: en = ~v_o | ready_i. It is global, and all three stages advance together when en = 1. Bubbles are not squeezed out.
- ready_o = en & (sof_i ? filter_v_i : (filter_v_i | kloaded_r)).
  - A sof window is never accepted without a valid kernel.
  - A non-sof window before the first kernel load is accepted only when filter_v_i = 1; it then uses filter_i without latching it.
- Kernel selection for an accepted window:
  - kern = (sof_i | ~kloaded_r) ? filter_i : kernel_r.
  - On an accepted sof window: kernel_r <= filter_i and kloaded_r <= 1.
  - Outside accepted sof windows, kernel_r holds regardless of filter_i changes.
- Stage 1:
  - Nine products: signed(kern[r][c]) * signed({1'b0, window[r][c]}).
  - Each product is COEF_W+PIXEL_W+1 = 18 bits signed, registered.
- Stage 2: three row sums of three products each, 20 bits signed, registered.
- Stage 3:
  - Total = sum of the row sums, 22 bits signed; the 9-term worst case of ±587,520 fits.
  - Shifted = total >>> SHIFT (arithmetic).
  - Saturate: < 0 gives 0; > 2^PIXEL_W - 1 gives 255; otherwise the low PIXEL_W bits.
  - Result is registered into data_o and v_o.
- Latency:
  - A window accepted in cycle N produces v_o = 1 in cycle N+3 when downstream does not stall.
  - Throughput is 1 pixel per clock with ready_i held at 1.
- Stall: with ready_i = 0 and v_o = 1, en = 0, so ready_o = 0 and every stage register and kernel_r holds.
- Simultaneous output transfer and new input: allowed when ready_i = 1; the pipeline shifts normally.
- filter_v_i falling mid-frame: has no effect while kloaded_r = 1 and sof_i = 0.
- Reset mid-operation: in-flight pixels are discarded and the kernel reverts to identity.
- Ordering: output order equals input order; no reordering and no drop except on reset.

Decomposition:
- conv_pkg:
  - Constants PIXEL_W, COEF_W, PROD_W = 18, ROW_W = 20, SUM_W = 22.
  - Typedefs kernel_t ([2:0][2:0][COEF_W-1:0]) and window_t ([2:0][2:0][PIXEL_W-1:0]).
  - Constant KERNEL_IDENTITY.
- Sub-module conv_sat: combinational shift plus clamp of a SUM_W signed value to PIXEL_W unsigned. Instantiated once in stage 3.

Test Plan:
- Identity: filter_i = identity with filter_v_i = 1, sof window with centre = 77 and others = 200 -> data_o = 77 at cycle N+3.
- Highpass: kernel (-1 ring, centre 8) on a flat window of 100 -> 0. Centre = 255 with others 0 -> 255 (2040 saturated). Centre = 0 with others 255 -> 0 (-2040 clamped).
- Emboss: kernel (-2, -1, 0; -1, 1, 1; 0, 1, 2) on window rows (10,20,30; 40,50,60; 70,80,90) -> -20 - 20 - 40 + 50 + 60 + 80 + 180 = 290 -> 255.
- Kernel hold: load the identity at sof, switch filter_i to sharpen mid-frame, send window centre = 50 with others 10 -> 50 (identity still used). The next sof window with the same data -> 5*50 - 40 = 210.
- Backpressure: stream 8 windows with ready_i toggling 1,0,0,1 -> all 8 results delivered in order, none duplicated. ready_o = 0 on exactly the cycles with v_o & ~ready_i.
- Reset mid-stream: assert reset_i with 3 pixels in flight -> v_o = 0 immediately (asynchronously). After release, a non-sof window with filter_v_i = 0 -> ready_o = 0.
